// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the N-to-1 arbitrating mux.
// Optional grant counters are enabled with MUX_ARB_GRANT_CNT_EN.
package mux_arb_pkg;
  localparam logic MODE_FIXED  = 1'b0;
  localparam logic MODE_RR     = 1'b1;
  localparam int   GRANT_CNT_W = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostage_e;
endpackage

// File: rtl/mux_arb_nto1_rr_pick.sv
// Rotating-priority encoder: first asserted request at or after start,
// wrapping from NUM_CH-1 back to 0.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  start,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_vld
);
  logic [SEL_W-1:0] w_idx;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    w_idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_idx = SEL_W'((int'(start) + k) % NUM_CH);
      if (req[w_idx]) begin
        gnt_idx = w_idx;
        gnt_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 valid/ready mux with fixed-select or round-robin grant and a
// registered output stage. Define MUX_ARB_GRANT_CNT_EN for per-channel grant counters.
module mux_arb_nto1
  import mux_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         select,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch
`ifdef MUX_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_CH*GRANT_CNT_W-1:0] grant_cnt
`endif
);
  ostage_e           r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_ptr;
  logic [DATA_W-1:0] r_data_p1;
  logic [SEL_W-1:0]  r_ch_p1;

  logic [SEL_W-1:0]  w_rr_idx, w_gnt_idx, w_ptr_nxt;
  logic              w_rr_vld, w_fix_vld, w_gnt_vld;
  logic              w_load_en, w_xfer;
  logic [DATA_W-1:0] w_sel_data;

  rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
    .req     (in_valid),
    .start   (r_ptr),
    .gnt_idx (w_rr_idx),
    .gnt_vld (w_rr_vld)
  );

  assign w_fix_vld = (int'(select) < NUM_CH) && in_valid[select];
  assign w_gnt_idx = (mode == MODE_RR) ? w_rr_idx : select;
  assign w_gnt_vld = (mode == MODE_RR) ? w_rr_vld : w_fix_vld;
  // Gating by rst_n keeps every in_ready low for the whole reset window.
  assign w_load_en = rst_n && ((r_state == ST_EMPTY) || out_ready);
  assign w_xfer    = w_load_en && w_gnt_vld;
  assign w_ptr_nxt = (w_gnt_idx == SEL_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + SEL_W'(1);

  always_comb begin
    in_ready   = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_gnt_idx == SEL_W'(i)) begin
        w_sel_data = in_data[i*DATA_W +: DATA_W];
      end
    end
    if (w_xfer) begin
      in_ready[w_gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer) begin
      w_state_nxt = ST_FULL;
    end else if ((r_state == ST_FULL) && out_ready) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer && (mode == MODE_RR)) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  // ---- output register stage (p1) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_p1 <= '0;
      r_ch_p1   <= '0;
    end else if (w_xfer) begin
      r_data_p1 <= w_sel_data;
      r_ch_p1   <= w_gnt_idx;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data_p1;
  assign out_ch    = r_ch_p1;

`ifdef MUX_ARB_GRANT_CNT_EN
  function automatic logic [GRANT_CNT_W-1:0] sat_inc(input logic [GRANT_CNT_W-1:0] v);
    return (v == {GRANT_CNT_W{1'b1}}) ? v : v + GRANT_CNT_W'(1);
  endfunction

  logic [GRANT_CNT_W-1:0] r_cnt [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_xfer && (w_gnt_idx == SEL_W'(i))) r_cnt[i] <= sat_inc(r_cnt[i]);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_out
    assign grant_cnt[g*GRANT_CNT_W +: GRANT_CNT_W] = r_cnt[g];
  end
`endif
endmodule

// File: tb/tb_mux_arb_nto1.sv
// Self-checking bench for mux_arb_nto1: reference model plus directed checks.
module tb_mux_arb_nto1;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     mode = 1'b0;
  logic [SEL_W-1:0]         select = '0;
  logic [NUM_CH-1:0]        in_valid = '0;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
`ifdef MUX_ARB_GRANT_CNT_EN
  logic [NUM_CH*16-1:0]     grant_cnt;
`endif

  mux_arb_nto1 #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .select    (select),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
`ifdef MUX_ARB_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: output register contents, RR pointer, grant counts.
  bit          m_vld  = 0;
  int          m_data = 0;
  int          m_ch   = 0;
  int          m_ptr  = 0;
  int          m_cnt [NUM_CH];

  function automatic void model_grant(output bit v, output int g);
    v = 0;
    g = 0;
    if (mode == 1'b0) begin
      if (int'(select) < NUM_CH && in_valid[select]) begin
        v = 1;
        g = int'(select);
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        int idx = (m_ptr + k) % NUM_CH;
        if (!v && in_valid[idx]) begin
          v = 1;
          g = idx;
        end
      end
    end
  endfunction

  function automatic logic [NUM_CH-1:0] model_ready();
    bit v;
    int g;
    logic [NUM_CH-1:0] r;
    r = '0;
    model_grant(v, g);
    if (rst_n && (!m_vld || out_ready) && v) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit v;
    int g;
    if (!rst_n) begin
      m_vld = 0; m_data = 0; m_ch = 0; m_ptr = 0;
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    end else begin
      model_grant(v, g);
      if (!m_vld || out_ready) begin
        if (v) begin
          m_vld  = 1;
          m_data = int'(in_data[g*DATA_W +: DATA_W]);
          m_ch   = g;
          if (mode == 1'b1) m_ptr = (g + 1) % NUM_CH;
          if (m_cnt[g] < 65535) m_cnt[g]++;
        end else begin
          m_vld = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  64'(in_ready),  64'(model_ready()));
    chk("out_valid", 64'(out_valid), 64'(m_vld));
    chk("out_data",  64'(out_data),  64'(m_data));
    chk("out_ch",    64'(out_ch),    64'(m_ch));
`ifdef MUX_ARB_GRANT_CNT_EN
    for (int i = 0; i < NUM_CH; i++)
      chk("grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
  end

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    nxt(); nxt();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);

    // Fixed mode
    #1 rst_n = 1'b1; mode = 1'b0; select = 2'd2; in_valid = 4'b0100;
    #1 chk("fix_in_ready", 64'(in_ready), 64'b0100);
    nxt();
    chk("fix_data", 64'(out_data), 64'hA5);
    chk("fix_ch",   64'(out_ch),   64'd2);
    chk("fix_vld",  64'(out_valid), 64'd1);
    #1 select = 2'd3;
    #1 chk("fix_nogrant_rdy", 64'(in_ready), 64'd0);
    nxt();
    chk("fix_drain_vld", 64'(out_valid), 64'd0);

    // Round-robin fairness
    #1 mode = 1'b1; in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      nxt();
      chk("rr_seq_ch",  64'(out_ch), 64'(k % 4));
      chk("rr_seq_vld", 64'(out_valid), 64'd1);
    end
    chk("rr_last_data", 64'(out_data), 64'h44);

    // Backpressure
    #1 out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nxt();
      chk("bp_ch",    64'(out_ch),   64'd3);
      chk("bp_data",  64'(out_data), 64'h44);
      chk("bp_ready", 64'(in_ready), 64'd0);
    end
    #1 out_ready = 1'b1;
    #1 chk("bp_release_rdy", 64'(in_ready), 64'b0001);
    nxt();
    chk("bp_reload_ch",   64'(out_ch),    64'd0);
    chk("bp_reload_data", 64'(out_data),  64'h11);
    chk("bp_reload_vld",  64'(out_valid), 64'd1);

    // Skip/wrap: single ch2 request moves ptr to 3, then 1010 -> 3,1,3
    #1 in_valid = 4'b0100;
    nxt();
    chk("wrap_pre_ch", 64'(out_ch), 64'd2);
    #1 in_valid = 4'b1010;
    nxt(); chk("wrap_ch_a", 64'(out_ch), 64'd3);
    nxt(); chk("wrap_ch_b", 64'(out_ch), 64'd1);
    chk("wrap_data_b", 64'(out_data), 64'h22);
    nxt(); chk("wrap_ch_c", 64'(out_ch), 64'd3);
    #1 in_valid = 4'b0000;
    nxt();
    chk("idle_vld", 64'(out_valid), 64'd0);

    // Mixed traffic, model-checked each cycle
    for (int k = 0; k < 60; k++) begin
      #1;
      in_valid  = NUM_CH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = 1'($urandom);
      select    = SEL_W'($urandom);
      in_data   = {$urandom, $urandom};
      nxt();
    end

    // Reset while a word is held
    #1 mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
    nxt(); nxt();
    chk("mid_full_vld", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld",  64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data),  64'd0);
    chk("mid_rst_rdy",  64'(in_ready),  64'd0);
    nxt(); nxt();

`ifdef MUX_ARB_GRANT_CNT_EN
    #1 rst_n = 1'b1; mode = 1'b0; select = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 select = 2'd0; in_valid = 4'b0001;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("cnt_ch0_sat", 64'(grant_cnt[15:0]),  64'hFFFF);
    chk("cnt_ch1",     64'(grant_cnt[31:16]), 64'd3);
    chk("cnt_ch2",     64'(grant_cnt[47:32]), 64'd0);
    chk("cnt_ch3",     64'(grant_cnt[63:48]), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_arb_nto1.md
Name: mux_arb_nto1

Overview:
Parametrised N-to-1 data multiplexer with per-channel valid/ready handshakes and a registered output stage.
Two selection modes:
- Fixed: an external select picks the channel, as the combinational 4-to-1 mux does.
- Round-robin: channels are arbitrated fairly.
Sits between multiple producer channels and a single consumer.

Parameters:
- NUM_CH, 4, number of input channels (>=2).
- DATA_W, 8, width of each channel's data word.
- SEL_W, $clog2(NUM_CH), derived localparam, not overridable; width of select/out_ch.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- mode  in  1  0 = fixed select, 1 = round-robin.
- select  in  SEL_W  channel index used in fixed mode.
- in_valid  in  NUM_CH  per-channel data valid; bit i = channel i.
- in_ready  out  NUM_CH  per-channel accept; bit i = channel i.
- in_data  in  NUM_CH*DATA_W  packed channel data; channel i at [i*DATA_W +: DATA_W].
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the output word.
- out_data  out  DATA_W  registered output word.
- out_ch  out  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, RR pointer ptr=0, in_ready=all 0.
- Output stage states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
  - load_en = EMPTY | (FULL & out_ready).
- Grant (combinational):
  - Fixed mode: grant channel = select when in_valid[select]=1 and select<NUM_CH; otherwise no grant.
  - RR mode: first i with in_valid[i]=1, scanning ptr, ptr+1, ..., wrapping NUM_CH-1 -> 0; no grant if all in_valid are 0.
- in_ready[i] = load_en & grant valid & (grant==i); at most one bit set, all others 0.
- Transfer: in_valid[i] & in_ready[i] at a clk edge loads out_data<=in_data[i], out_ch<=i, out_valid<=1.
- Latency: one cycle from input acceptance to out_valid.
- Throughput: one word per cycle while out_ready=1.
- FULL & out_ready & no grant -> EMPTY (out_valid<=0).
- FULL & !out_ready -> hold: out_data, out_ch, out_valid stable; all in_ready=0.
- Simultaneous output drain and new input in the same cycle: the new word replaces the old one, out_valid stays 1, no bubble.
- ptr update: only on an accepted transfer in RR mode, ptr<=(granted+1) wrapping at NUM_CH-1 -> 0. ptr is held in fixed mode.
- Mode or select changes take effect at the next grant decision. A word already in the output register is unaffected.
- Reset asserted mid-transfer: the held word is discarded immediately; no in_ready is asserted while rst_n=0.
- Producers must hold in_data and in_valid until accepted; the block does not check this.

Optional Feature:
- Macro MUX_ARB_GRANT_CNT_EN.
- When defined:
  - Extra output port grant_cnt, width NUM_CH*16.
  - Per-channel 16-bit counter, incremented on each accepted transfer from that channel.
  - Saturates at 16'hFFFF; cleared by reset.
- When undefined: the port and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package mux_arb_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - GRANT_CNT_W=16.
  - Output-stage state enum {ST_EMPTY, ST_FULL}.
- Sub-module rr_pick: rotating-priority encoder.
  - Inputs: req[NUM_CH], start[SEL_W].
  - Outputs: gnt_idx, gnt_vld.
  - Instantiated once; fixed mode bypasses it.

Test Plan:
- Reset: rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0000.
- Fixed mode, NUM_CH=4, DATA_W=8:
  - Setup: select=2, in_data ch2=8'hA5, in_valid=0100, out_ready=1 -> next cycle out_data=A5, out_ch=2.
  - Then select=3 with in_valid[3]=0 -> in_ready=0000, out_valid drops to 0.
- RR fairness: in_valid=1111 held, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3, one word per cycle.
- Backpressure: out_ready=0 for 3 cycles while FULL -> out_data and out_ch stable, in_ready=0000. Then out_ready=1 -> next channel loads in the same cycle as the drain.
- RR skip/wrap: ptr=3, in_valid=1010 -> grants ch3, then ch1 (wrap past 0), then ch3.
- With MUX_ARB_GRANT_CNT_EN defined: 70000 grants on ch0 -> grant_cnt[15:0]=16'hFFFF, other channels' counts exact.
